// File: rtl/mips_pkg.sv
// Shared MIPS core constants.
// Imported by the register file, hazard and forwarding units.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_rd_port.sv
// One register-file read port.
// Handles zero/bypass/select muxing, the optional output register and busy.
module regfile_rd_port
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int SYNC_READ = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   busy,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_busy
);

  logic              is_zero;
  logic              hit;
  logic [DATA_W-1:0] val;

  assign is_zero = (ZERO_REG != 0) &&
                   (rd_addr == ADDR_W'(REG_ZERO));

  // Zero wins over bypass, keeping the two select terms exclusive.
  assign hit = (BYPASS != 0) && wr_en &&
               (wr_addr == rd_addr) && !is_zero;

  always_comb begin
    val = regs[rd_addr];
    unique case (1'b1)
      is_zero: val = '0;
      hit:     val = wr_data;
      default: val = regs[rd_addr];
    endcase
  end

  assign rd_busy = busy[rd_addr] & ~hit;

  generate
    if (SYNC_READ != 0) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data <= '0;
        end else if (rd_en) begin
          rd_data <= val;
        end
      end
    end else begin : g_comb
      assign rd_data = val;
    end
  endgenerate

endmodule

// File: rtl/mips_regfile_sb.sv
// Decode-stage register file with per-register scoreboard.
// Storage, busy bits and debug flattening live here; ports are submodules.
module mips_regfile_sb
  import mips_pkg::*;
#(
  parameter int DATA_W    = mips_pkg::DATA_W,
  parameter int ADDR_W    = mips_pkg::ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int SYNC_READ = 1,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [2**ADDR_W-1:0]       busy_vec,
  output logic [(2**ADDR_W)*DATA_W-1:0] dbg_regs
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_ok;
  logic              iss_ok;

  assign wr_ok  = wr_en &
                  ~((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));
  assign iss_ok = iss_en &
                  ~((ZERO_REG != 0) && (iss_addr == ADDR_W'(REG_ZERO)));

  // Issue is applied after writeback so a fresh writer stays pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  assign busy_vec = busy;

  always_comb begin
    dbg_regs = '0;
    for (int i = 0; i < DEPTH; i++)
      dbg_regs[(DEPTH-1-i)*DATA_W +: DATA_W] = regs[i];
  end

  generate
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_rd_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .SYNC_READ (SYNC_READ),
        .BYPASS    (BYPASS),
        .ZERO_REG  (ZERO_REG)
      ) u_port (
        .clk     (clk),
        .reset   (reset),
        .rd_en   (rd_en[p]),
        .rd_addr (rd_addr[p*ADDR_W +: ADDR_W]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .regs    (regs),
        .busy    (busy),
        .rd_data (rd_data[p*DATA_W +: DATA_W]),
        .rd_busy (rd_busy[p])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mips_regfile_sb.sv
// Bench for mips_regfile_sb: a sync/bypass instance and a comb/no-bypass
// instance share stimulus and are checked against an array model.
module tb_mips_regfile_sb;

  logic        clk = 0;
  logic        reset;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0]   a_rd_data, b_rd_data;
  logic [1:0]    a_rd_busy, b_rd_busy;
  logic [31:0]   a_busy, b_busy;
  logic [1023:0] a_dbg, b_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_regfile_sb u_a (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(a_rd_data), .rd_busy(a_rd_busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(a_busy), .dbg_regs(a_dbg)
  );

  mips_regfile_sb #(.SYNC_READ(0), .BYPASS(0)) u_b (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(b_rd_data), .rd_busy(b_rd_busy), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en),
    .iss_addr(iss_addr), .busy_vec(b_busy), .dbg_regs(b_dbg)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] dslice(logic [1023:0] d, int i);
    return d[(31-i)*32 +: 32];
  endfunction

  // Model
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  logic [31:0] m_rd   [2];
  bit          armed = 0;

  function automatic logic [31:0] mval(logic [4:0] a, bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return wr_data;
    return m_regs[a];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 0;
        m_busy[i] = 0;
      end
      m_rd[0] = 0;
      m_rd[1] = 0;
      armed = 1;
    end else begin
      for (int p = 0; p < 2; p++)
        if (rd_en[p]) m_rd[p] = mval(rd_addr[p*5 +: 5], 1);
      if (wr_en && wr_addr != 0) begin
        m_regs[wr_addr] = wr_data;
        m_busy[wr_addr] = 0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 32; i++) begin
        chk("a_dbg", dslice(a_dbg, i), m_regs[i]);
        chk("b_dbg", dslice(b_dbg, i), m_regs[i]);
        chk("a_busyvec", {31'b0, a_busy[i]}, {31'b0, m_busy[i]});
        chk("b_busyvec", {31'b0, b_busy[i]}, {31'b0, m_busy[i]});
      end
      for (int p = 0; p < 2; p++) begin
        logic [4:0] ad;
        ad = rd_addr[p*5 +: 5];
        chk("a_rd_data", a_rd_data[p*32 +: 32], m_rd[p]);
        chk("b_rd_data", b_rd_data[p*32 +: 32], mval(ad, 0));
        chk("a_rd_busy", {31'b0, a_rd_busy[p]},
            {31'b0, m_busy[ad] && !(wr_en && wr_addr == ad)});
        chk("b_rd_busy", {31'b0, b_rd_busy[p]}, {31'b0, m_busy[ad]});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    reset = 0; rd_en = 0; wr_en = 0; iss_en = 0;
  endtask

  initial begin
    reset = 1; rd_en = 0; rd_addr = 0;
    wr_en = 1; wr_addr = 3; wr_data = 32'h55; iss_en = 1; iss_addr = 4;
    cyc();
    idle();

    rd_en = 2'b11; rd_addr = {5'd31, 5'd5};
    cyc();
    chk("rst_rd0", a_rd_data[31:0], 32'h0);
    chk("rst_rd1", a_rd_data[63:32], 32'h0);
    chk("rst_busy", a_busy, 32'h0);
    chk("rst_dbg", {31'b0, a_dbg == '0}, 32'h1);

    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    cyc();
    idle(); rd_en = 2'b01; rd_addr = {5'd0, 5'd7};
    #1 chk("comb_rd7", b_rd_data[31:0], 32'hDEADBEEF);
    cyc();
    chk("sync_rd7", a_rd_data[31:0], 32'hDEADBEEF);

    idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h11111111;
    cyc();
    idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h12345678;
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    #1 chk("nobyp_rd9", b_rd_data[63:32], 32'h11111111);
    chk("byp_busy", {30'b0, a_rd_busy}, 32'h0);
    cyc();
    chk("byp_rd0", a_rd_data[31:0], 32'h12345678);
    chk("byp_rd1", a_rd_data[63:32], 32'h12345678);

    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
    iss_en = 1; iss_addr = 0;
    cyc();
    idle(); rd_en = 2'b11; rd_addr = 10'd0;
    chk("z_busy0", {31'b0, a_busy[0]}, 32'h0);
    chk("z_dbg0", dslice(a_dbg, 0), 32'h0);
    cyc();
    chk("z_rd0", a_rd_data[31:0], 32'h0);

    idle(); iss_en = 1; iss_addr = 12;
    cyc();
    idle(); rd_addr = {5'd0, 5'd12};
    chk("sb_set", {31'b0, a_busy[12]}, 32'h1);
    #1 chk("sb_rdbusy", {31'b0, a_rd_busy[0]}, 32'h1);
    wr_en = 1; wr_addr = 12; wr_data = 32'hCAFE0012;
    #1 chk("sb_bypbusy", {31'b0, a_rd_busy[0]}, 32'h0);
    chk("sb_nobypbusy", {31'b0, b_rd_busy[0]}, 32'h1);
    cyc();
    chk("sb_clr", {31'b0, a_busy[12]}, 32'h0);
    idle(); wr_en = 1; wr_addr = 12; wr_data = 32'h0BADF00D;
    iss_en = 1; iss_addr = 12;
    cyc();
    chk("sb_both_busy", {31'b0, a_busy[12]}, 32'h1);
    chk("sb_both_data", dslice(a_dbg, 12), 32'h0BADF00D);

    idle(); wr_en = 1; wr_addr = 3; wr_data = 32'hA5A5A5A5;
    cyc();
    idle(); iss_en = 1; iss_addr = 3; rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    cyc();
    chk("mid_busy3", {31'b0, a_busy[3]}, 32'h1);
    chk("mid_rd3", a_rd_data[31:0], 32'hA5A5A5A5);
    idle(); reset = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h1;
    rd_en = 2'b11;
    cyc();
    idle();
    chk("mid_reg3", dslice(a_dbg, 3), 32'h0);
    chk("mid_busy", a_busy, 32'h0);
    chk("mid_rd", a_rd_data[31:0], 32'h0);

    for (int k = 0; k < 300; k++) begin
      reset    = ($urandom_range(0, 39) == 0);
      rd_en    = 2'($urandom_range(0, 3));
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = 5'($urandom_range(0, 7));
      cyc();
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_regfile_sb.md
Name: mips_regfile_sb

Overview:
- Parametrised MIPS general-purpose register file for the decode stage of the pipelined core.
- Configurable data width, depth and read-port count; selectable registered or combinational reads.
- Optional write-to-read bypass and a hardwired-zero register 0.
- Integrated scoreboard: one busy bit per register, set when a writer issues and cleared at writeback, so the hazard unit can stall on pending results.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of independent read ports (1..4)
- SYNC_READ, 1, 1 = read data registered on clk; 0 = combinational read
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_en  in  NUM_RD  per-port read strobe (used only when SYNC_READ=1)
- rd_addr  in  NUM_RD*ADDR_W  port p address at bits [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  port p data at bits [p*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port p addressed register has a pending write (combinational)
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  writer issued; marks destination pending
- iss_addr  in  ADDR_W  issued destination
- busy_vec  out  DEPTH  scoreboard, bit i = register i pending
- dbg_regs  out  DEPTH*DATA_W  debug snapshot; register 0 in the most-significant slice, register DEPTH-1 in the least-significant slice

Behaviour:
- Reset is synchronous and active-high; clock is clk. Reset has priority over all other inputs in the same cycle.
- Reset clears all registers, busy bits and registered rd_data to 0. Any write or issue presented in the reset cycle is discarded.
- Write: at the edge, if wr_en, then reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
  - With ZERO_REG=1 and wr_addr=0, the write is dropped.
- Issue: at the edge, if iss_en, then busy[iss_addr] <= 1.
  - Issue and write to the same address in the same cycle: the register takes wr_data and busy ends 1 (issue wins, since a new writer is pending).
  - With ZERO_REG=1, issue to address 0 is ignored.
- Read value v(p):
  - 0 if ZERO_REG and rd_addr_p = 0.
  - Else wr_data if BYPASS, wr_en and wr_addr = rd_addr_p.
  - Else reg[rd_addr_p].
- SYNC_READ=1: rd_data_p <= v(p) at the edge when rd_en_p; holds otherwise. Latency is 1 cycle.
  - Without BYPASS, a same-cycle collision returns the old value (read-first).
- SYNC_READ=0: rd_data_p = v(p) combinationally, with rd_en ignored. Latency is 0.
- rd_busy_p = busy[rd_addr_p] & ~(BYPASS & wr_en & wr_addr = rd_addr_p). A bypassed read is not busy. Address 0 is never busy under ZERO_REG.
- All ports may address the same register simultaneously with identical results.
- busy_vec and dbg_regs reflect state after the last edge, with no bypass applied.

Decomposition:
- Shared package mips_pkg: DATA_W/ADDR_W defaults and a REG_ZERO = 0 constant, shared with the hazard and forwarding units.
- One natural sub-module, regfile_rd_port: a single read port holding the zero/bypass/select mux, the optional output register and rd_busy. It is instantiated NUM_RD times via generate.
- Storage, scoreboard and debug flattening stay in the top level.

Test Plan:
- Reset then read: reset high 1 cycle, then read addr 5 and 31 on both ports -> rd_data = 0 next cycle; busy_vec = 0; dbg_regs = 0.
- Write then read: write 0xDEADBEEF to reg 7, next cycle rd_en port0 addr 7 -> port0 = 0xDEADBEEF one cycle later (SYNC_READ=1); immediately (SYNC_READ=0).
- Bypass collision: same cycle write 0x12345678 to reg 9 and read reg 9 on both ports -> both ports = 0x12345678 with BYPASS=1, previous value with BYPASS=0; rd_busy = 0.
- Zero register: write 0xFFFFFFFF and issue to reg 0 -> reads of reg 0 return 0; busy_vec[0] = 0; dbg_regs top slice = 0.
- Scoreboard: issue reg 12 -> busy_vec[12] = 1 and rd_busy = 1 for a port on addr 12. Write reg 12 -> busy cleared next cycle. Issue + write reg 12 in the same cycle -> data updated, busy stays 1.
- Reset mid-operation: regs 3 = 0xA5A5A5A5 and busy[3] = 1, then reset asserted together with wr_en to reg 3 -> reg 3 = 0, busy[3] = 0, rd_data = 0 after the edge.
